// File: rtl/ntw_proto_pkg.sv
// Shared network-protocol constants and types for the IP protocol slots.
// Also holds the ICMP echo FSM states and the echo-reply checksum update.
package ntw_proto_pkg;

  localparam logic [7:0] PROTO_ICMP = 8'd1;
  localparam logic [7:0] PROTO_TCP  = 8'd6;
  localparam logic [7:0] PROTO_UDP  = 8'd17;

  localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;
  localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;

  localparam int IP_HDR_BYTES = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_DRAIN,
    ST_DECIDE,
    ST_TX_HDR,
    ST_TX_PLD
  } icmp_echo_state_t;

  // Type 8 -> 0 lowers the first checksummed word by 0x0800, so the
  // one's-complement checksum rises by 0x0800 with end-around carry.
  function automatic logic [15:0] icmp_echo_csum(input logic [15:0] csum);
    logic [16:0] s17;
    s17 = {1'b0, csum} + 17'h00800;
    return s17[15:0] + {15'd0, s17[16]};
  endfunction

endpackage

// File: rtl/ip_intf.sv
// IP header + 8-bit AXI-Stream payload bundle between protocol blocks.
interface ip_intf;

  logic        ip_hdr_valid;
  logic        ip_hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [15:0] ip_length;
  logic [3:0]  ip_ihl;
  logic [7:0]  ip_ttl;
  logic [7:0]  ip_protocol;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;

  logic [7:0]  ip_payload_axis_tdata;
  logic        ip_payload_axis_tvalid;
  logic        ip_payload_axis_tready;
  logic        ip_payload_axis_tlast;
  logic        ip_payload_axis_tuser;

  modport MASTER (
    output ip_hdr_valid, ip_dscp, ip_ecn, ip_length, ip_ttl, ip_protocol,
           ip_source_ip, ip_dest_ip,
           ip_payload_axis_tdata, ip_payload_axis_tvalid,
           ip_payload_axis_tlast, ip_payload_axis_tuser,
    input  ip_hdr_ready, ip_payload_axis_tready
  );

  modport SLAVE (
    input  ip_hdr_valid, ip_length, ip_ihl, ip_protocol,
           ip_source_ip, ip_dest_ip,
           ip_payload_axis_tdata, ip_payload_axis_tvalid,
           ip_payload_axis_tlast, ip_payload_axis_tuser,
    output ip_hdr_ready, ip_payload_axis_tready
  );

endinterface

// File: rtl/icmp_echo_buf.sv
// Simple dual-port byte buffer: one write port, one registered read port.
module icmp_echo_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; every byte is
  // written before it is read back, so its power-up contents never matter.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/icmp_echo_responder.sv
// Store-and-forward ICMP echo responder: buffers each message, answers echo
// requests with swapped addresses and an updated checksum, drops the rest.
module icmp_echo_responder
  import ntw_proto_pkg::*;
#(
  parameter int         BUF_DEPTH = 256,
  parameter logic [7:0] REPLY_TTL = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ip_intf.SLAVE       s_ip,
  ip_intf.MASTER      m_ip,
  output logic [15:0] o_echo_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int          AW         = $clog2(BUF_DEPTH);
  localparam logic [15:0] HDR_LEN    = 16'(IP_HDR_BYTES);
  localparam logic [15:0] MIN_IP_LEN = HDR_LEN + 16'd8;
  localparam logic [16:0] MAX_IP_LEN = 17'(BUF_DEPTH + IP_HDR_BYTES);
  localparam logic [16:0] BUF_BYTES  = 17'(BUF_DEPTH);

  icmp_echo_state_t state, state_nxt;

  logic        hdr_ready_q;
  logic [15:0] len_q;
  logic [31:0] src_q, dst_q;
  logic [15:0] byte_cnt;
  logic [7:0]  icmp_type;
  logic [15:0] csum_q;
  logic        tuser_seen;

  logic [15:0] rd_ptr, ram_idx;
  logic        ram_vld;
  logic [7:0]  ram_data;
  logic        out_vld, out_last;
  logic [7:0]  out_data;
  logic [7:0]  sub_data;

  logic [15:0] hdr_len_q;
  logic [31:0] hdr_src_q, hdr_dst_q;
  logic [7:0]  hdr_ttl_q, hdr_proto_q;

  logic [15:0] pld_len, csum_new;
  logic hdr_fire, hdr_bad, rx_beat, rx_last, decide_drop;
  logic tx_run, tx_fire, tx_done, out_free, adv, rd_en, wr_en;

  assign pld_len  = len_q - HDR_LEN;
  assign csum_new = icmp_echo_csum(csum_q);

  assign hdr_fire = (state == ST_IDLE) && hdr_ready_q && s_ip.ip_hdr_valid;
  assign hdr_bad  = (s_ip.ip_ihl != 4'd5) || (s_ip.ip_protocol != PROTO_ICMP) ||
                    (s_ip.ip_length < MIN_IP_LEN) || ({1'b0, s_ip.ip_length} > MAX_IP_LEN);
  assign rx_beat  = s_ip.ip_payload_axis_tvalid && s_ip.ip_payload_axis_tready;
  assign rx_last  = rx_beat && s_ip.ip_payload_axis_tlast;
  assign decide_drop = tuser_seen || (byte_cnt != pld_len) || (icmp_type != ICMP_ECHO_REQUEST);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt                   = state;
    s_ip.ip_payload_axis_tready = 1'b0;
    m_ip.ip_hdr_valid           = 1'b0;
    unique case (state)
      ST_IDLE:   if (hdr_fire) state_nxt = hdr_bad ? ST_DRAIN : ST_RX;
      ST_RX: begin
        s_ip.ip_payload_axis_tready = 1'b1;
        if (rx_last) state_nxt = ST_DECIDE;
      end
      ST_DRAIN: begin
        s_ip.ip_payload_axis_tready = 1'b1;
        if (rx_last) state_nxt = ST_IDLE;
      end
      ST_DECIDE: state_nxt = decide_drop ? ST_IDLE : ST_TX_HDR;
      ST_TX_HDR: begin
        m_ip.ip_hdr_valid = 1'b1;
        if (m_ip.ip_hdr_ready) state_nxt = ST_TX_PLD;
      end
      ST_TX_PLD: if (tx_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      hdr_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      hdr_ready_q <= (state_nxt == ST_IDLE);
    end
  end

  assign s_ip.ip_hdr_ready = hdr_ready_q;

  // Receive side: header latch, byte counter and ICMP header capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      byte_cnt   <= '0;
      icmp_type  <= '0;
      csum_q     <= '0;
      tuser_seen <= 1'b0;
    end else if (hdr_fire) begin
      len_q      <= s_ip.ip_length;
      src_q      <= s_ip.ip_source_ip;
      dst_q      <= s_ip.ip_dest_ip;
      byte_cnt   <= '0;
      tuser_seen <= 1'b0;
    end else if (state == ST_RX && rx_beat) begin
      if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      if (s_ip.ip_payload_axis_tuser) tuser_seen <= 1'b1;
      case (byte_cnt)
        16'd0:   icmp_type     <= s_ip.ip_payload_axis_tdata;
        16'd2:   csum_q[15:8]  <= s_ip.ip_payload_axis_tdata;
        16'd3:   csum_q[7:0]   <= s_ip.ip_payload_axis_tdata;
        default: ;
      endcase
    end
  end

  assign wr_en = (state == ST_RX) && rx_beat && ({1'b0, byte_cnt} < BUF_BYTES);

  icmp_echo_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .i_clk   (i_clk),
    .wr_en   (wr_en),
    .wr_addr (byte_cnt[AW-1:0]),
    .wr_data (s_ip.ip_payload_axis_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_data)
  );

  // Transmit side: RAM output stage plus output register. The first read is
  // issued in DECIDE so byte 0 is ready the cycle after the header handshake.
  assign tx_run   = (state == ST_DECIDE) || (state == ST_TX_HDR) || (state == ST_TX_PLD);
  assign tx_fire  = m_ip.ip_payload_axis_tvalid && m_ip.ip_payload_axis_tready;
  assign tx_done  = tx_fire && out_last;
  assign out_free = !out_vld || tx_fire;
  assign adv      = ram_vld && out_free;
  assign rd_en    = tx_run && (rd_ptr < pld_len) && (!ram_vld || adv);

  always_comb begin
    sub_data = ram_data;
    case (ram_idx)
      16'd0:   sub_data = ICMP_ECHO_REPLY;
      16'd2:   sub_data = csum_new[15:8];
      16'd3:   sub_data = csum_new[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr   <= '0;
      ram_idx  <= '0;
      ram_vld  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (!tx_run) begin
      rd_ptr  <= '0;
      ram_vld <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 16'd1;
        ram_idx <= rd_ptr;
      end
      ram_vld <= rd_en || (ram_vld && !adv);
      if (adv) begin
        out_vld  <= 1'b1;
        out_data <= sub_data;
        out_last <= (ram_idx == pld_len - 16'd1);
      end else if (tx_fire) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign m_ip.ip_payload_axis_tvalid = out_vld && (state == ST_TX_PLD);
  assign m_ip.ip_payload_axis_tdata  = out_data;
  assign m_ip.ip_payload_axis_tlast  = out_last;
  assign m_ip.ip_payload_axis_tuser  = 1'b0;

  // Reply header registers, loaded as the FSM commits to a reply.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hdr_len_q   <= '0;
      hdr_src_q   <= '0;
      hdr_dst_q   <= '0;
      hdr_ttl_q   <= '0;
      hdr_proto_q <= '0;
    end else if (state == ST_DECIDE && !decide_drop) begin
      hdr_len_q   <= len_q;
      hdr_src_q   <= dst_q;
      hdr_dst_q   <= src_q;
      hdr_ttl_q   <= REPLY_TTL;
      hdr_proto_q <= PROTO_ICMP;
    end
  end

  assign m_ip.ip_dscp      = 6'd0;
  assign m_ip.ip_ecn       = 2'd0;
  assign m_ip.ip_length    = hdr_len_q;
  assign m_ip.ip_ttl       = hdr_ttl_q;
  assign m_ip.ip_protocol  = hdr_proto_q;
  assign m_ip.ip_source_ip = hdr_src_q;
  assign m_ip.ip_dest_ip   = hdr_dst_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_echo_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (state == ST_TX_PLD && tx_done) o_echo_cnt <= o_echo_cnt + 16'd1;
      if ((state == ST_DRAIN && rx_last) || (state == ST_DECIDE && decide_drop))
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: doc/icmp_echo_responder.md
# icmp_echo_responder

Store-and-forward ICMP echo responder for the network processor's ICMP protocol slot. It consumes IP packets from the ICMP output of the receive-side protocol demux and buffers each ICMP message whole. It turns every valid echo request (type 8) into an echo reply (type 0) with swapped addresses and an incrementally corrected checksum. The reply goes to the ICMP input of the transmit-side IP arbiter; all other ICMP traffic is drained and counted.

## Interface
- BUF_DEPTH, 256: payload buffer size in bytes (power of two); largest ICMP message (IP length − 20) replied to.
- REPLY_TTL, 64: TTL placed in reply headers.
- i_clk  in  1  system clock; all logic synchronous to it.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- s_ip  ip_intf.SLAVE  8-bit data  received ICMP packets: header (hdr_valid/ready, length, ihl, protocol, source_ip, dest_ip) plus payload AXIS (tdata, tvalid, tready, tlast, tuser).
- m_ip  ip_intf.MASTER  8-bit data  reply packets: hdr_valid/ready, dscp, ecn, length, ttl, protocol, source_ip, dest_ip, payload AXIS.
- o_echo_cnt  out  16  replies sent, wrapping.
- o_drop_cnt  out  16  packets dropped, wrapping.

## Operation
- States: IDLE, RX, DRAIN, DECIDE, TX_HDR, TX_PLD.
- IDLE:
  - s_ip.ip_hdr_ready=1.
  - On header handshake, latch length, source_ip and dest_ip; clear the byte counter.
  - Go to DRAIN if ihl≠5, protocol≠1, length<28 or length−20>BUF_DEPTH; otherwise go to RX.
- RX:
  - payload tready=1.
  - Each beat writes the buffer at the byte counter, then the counter increments.
  - Bytes 0–3 are also captured: type, code, checksum hi/lo.
  - On the tlast beat, go to DECIDE.
- DRAIN:
  - tready=1; bytes are discarded.
  - On tlast, increment o_drop_cnt and return to IDLE.
- DECIDE (one cycle):
  - Drop (o_drop_cnt+1, go to IDLE) if any of: tuser seen on any beat, byte count ≠ length−20, or type≠8.
  - Otherwise go to TX_HDR.
- TX_HDR:
  - m_ip.ip_hdr_valid=1 with dscp=0, ecn=0, length=latched length, ttl=REPLY_TTL, protocol=1.
  - source_ip = latched dest_ip; dest_ip = latched source_ip.
  - On the handshake, go to TX_PLD.
- TX_PLD:
  - Stream count bytes from the buffer with tuser=0 and tlast on byte count−1.
  - Byte substitution: byte0=0x00; byte2/3 = new checksum hi/lo.
  - After the last handshake, increment o_echo_cnt and go to IDLE.
- Checksum rule (RFC 1624):
  - s17 = {0,csum} + 17'h0800; new = s17[15:0] + s17[16].
  - Examples: 0xF7FF→0xFFFF; 0xF900→0x0101.
- Buffer overflow is impossible because length is pre-checked. A short packet (tlast early) or long packet (count exceeds length−20) is dropped at DECIDE; writes beyond BUF_DEPTH are suppressed.
- One packet in flight: no header is accepted while in RX, DRAIN, DECIDE, TX_HDR or TX_PLD.

## Timing
- Reset values:
  - state=IDLE; all valids=0; s_ip.ip_hdr_ready=0 during reset and 1 the first cycle after.
  - payload tready=0; counters=0; m_ip header fields=0.
- Input throughput: one payload byte per cycle, no bubbles.
- Output timing:
  - m_ip.ip_hdr_valid rises 2 cycles after the input tlast handshake (DECIDE, then TX_HDR).
  - First payload tvalid comes the cycle after the header handshake; the buffer read is registered and prefetched.
  - Back-to-back bytes at full rate when tready=1.
- AXIS rules:
  - Once valid is asserted, valid and data are held stable until ready.
  - tready may toggle every cycle; a read-ahead register keeps data correct under any tready pattern.
- Reset mid-operation: immediate return to IDLE; any partial reply is abandoned (the downstream arbiter shares the reset).
- Counters update in the cycle of the final handshake (echo) or the DRAIN-tlast/DECIDE cycle (drop).

## Structure
- Shared package ntw_proto_pkg:
  - PROTO_ICMP/UDP/TCP constants;
  - ICMP_ECHO_REQUEST=8, ICMP_ECHO_REPLY=0;
  - IP_HDR_BYTES=20;
  - icmp_echo_state_t enum.
- Sub-module icmp_echo_buf: simple dual-port RAM, BUF_DEPTH×8, one write port, registered read port.
- Instantiated at proto_rx_ip[ICMP_IDX] / proto_tx_ip[ICMP_IDX], replacing the constant ready tie-offs.

## Test plan
- Ping: echo request, length 84, csum 0x4D2A, 56-byte pattern → reply type 0, csum 0x552A, IPs swapped, ttl 64, 64 bytes identical otherwise, o_echo_cnt=1.
- Non-echo: type 0 input, length 28 → no m_ip activity, all bytes accepted, o_drop_cnt=1.
- Oversize: length 20+BUF_DEPTH+1 → drained, no reply; a following valid 28-byte request is answered.
- Errors:
  - tuser=1 on the last beat → dropped.
  - Length field 60 with 30 bytes delivered → dropped.
- Backpressure: random m_ip tready (30% duty) with checksum 0xF7FF → byte-exact reply with csum 0xFFFF, tlast exactly on byte count−1.
- Reset asserted during TX_PLD at byte 10 → all valids 0 asynchronously, counters 0; the next request is answered normally.
